// File: rtl/conv_relu_maxpool.sv
// conv_relu_maxpool: ReLU plus 2x2 stride-2 max pooling over a row-major pixel stream,
// with a single-entry valid/ready output register that back-pressures the producer.
module conv_relu_maxpool #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    output logic              o_done,
    output logic [1:0]        o_state
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                   r_state, w_next;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W-1:0] r_lb [IMG_W/2];
    logic signed [DATA_W-1:0] w_x, w_lb, w_m1, w_m2;
    logic                     w_xfer, w_col_end, w_row_end, w_load;

    assign w_x       = i_in_data;
    assign w_lb      = r_lb[r_col[CW-1:1]];
    assign w_m1      = (r_h > w_x) ? r_h : w_x;
    assign w_m2      = (w_lb > w_m1) ? w_lb : w_m1;
    assign o_in_ready = (r_state == RUN) && (!o_out_valid || i_out_ready);
    assign w_xfer    = i_in_valid && o_in_ready;
    assign w_col_end = r_col == CW'(IMG_W - 1);
    assign w_row_end = r_row == RW'(IMG_H - 1);
    assign w_load    = w_xfer && r_row[0] && r_col[0];
    assign o_done    = r_state == DONE;
    assign o_state   = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (w_xfer && w_col_end && w_row_end) ? FLUSH : RUN;
            FLUSH:   w_next = (!o_out_valid || i_out_ready) ? DONE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_xfer) begin
                r_col <= w_col_end ? '0 : r_col + CW'(1);
                if (w_col_end)
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
            end
            if (w_xfer && !r_col[0])
                r_h <= w_x;
            // ReLU folds into the pooled max: a negative window maximum clamps to zero
            if (w_load)
                o_out_data <= w_m2[DATA_W-1] ? '0 : w_m2;
            o_out_valid <= w_load || (o_out_valid && !i_out_ready);
        end
    end

    always_ff @(posedge i_clk)
        if (w_xfer && !r_row[0] && r_col[0])
            r_lb[r_col[CW-1:1]] <= w_m1;
endmodule

// File: tb/tb_conv_relu_maxpool.sv
// tb_conv_relu_maxpool: scoreboard bench for conv_relu_maxpool on a 4x4 frame.
module tb_conv_relu_maxpool;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready;
    logic        o_in_ready, o_out_valid, o_done;
    logic [15:0] o_out_data;
    logic [1:0]  o_state;

    int errors = 0, checks = 0, cyc = 0;
    int acc_cnt = 0, out_cnt = 0, done_cnt = 0;
    int last_hs_cyc = -10, last_acc_cyc = -10;
    logic [15:0] last_acc_data = '0;
    bit check_lat = 0, stall_arm = 0, force_low = 0;
    int stall_left = 0, start_at = -1;
    logic [15:0] q[$];
    logic signed [15:0] pix [16];

    conv_relu_maxpool #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(out_ready),
        .o_done(o_done), .o_state(o_state)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // consumer: ready high unless forced low or a 5-cycle stall is armed
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (force_low) out_ready = 1'b0;
            else if (stall_arm && o_out_valid) begin
                stall_arm = 0;
                stall_left = 4;
                out_ready = 1'b0;
            end else if (stall_left > 0) begin
                stall_left--;
                out_ready = 1'b0;
            end else out_ready = 1'b1;
        end
    end

    // scoreboard monitor
    initial forever begin
        logic [15:0] exp_v;
        @(negedge clk);
        if (rst_n && o_out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %0d, required no output", $signed(o_out_data));
            end else begin
                exp_v = q.pop_front();
                if (o_out_data !== exp_v) begin
                    errors++;
                    $display("FAIL out_data: got %0d, required %0d", $signed(o_out_data), $signed(exp_v));
                end
            end
            if (check_lat) begin
                checks++;
                if (last_acc_cyc != cyc - 1 || last_acc_data !== o_out_data) begin
                    errors++;
                    $display("FAIL out_latency: got input %0d at cycle %0d, required input %0d at cycle %0d",
                             last_acc_data, last_acc_cyc, o_out_data, cyc - 1);
                end
            end
            last_hs_cyc = cyc;
            out_cnt++;
        end
        if (o_done) begin
            checks++;
            done_cnt++;
            if (cyc != last_hs_cyc + 1) begin
                errors++;
                $display("FAIL done_timing: got cycle %0d, required %0d", cyc, last_hs_cyc + 1);
            end
        end
        if (in_valid && o_in_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            last_acc_data = in_data;
        end
    end

    task automatic drive_frame();
        int n;
        bit ok;
        logic signed [15:0] m, v;
        for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++) begin
                m = pix[2*pr*4 + 2*pc];
                for (int d = 0; d < 4; d++) begin
                    v = pix[(2*pr + d/2)*4 + 2*pc + d%2];
                    if (v > m) m = v;
                end
                q.push_back(m < 0 ? 16'sd0 : m);
            end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = pix[i];
            if (i == start_at) start = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                ok = o_in_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end while (!ok && n < 100);
            if (!ok) begin
                errors++;
                checks++;
                $display("FAIL in_accept_timeout: pixel %0d not accepted, required acceptance", i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 60);
        checks++;
        if (!o_done) begin
            errors++;
            $display("FAIL done_timeout: got o_done=0, required 1");
        end
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        int d0;
        #2;
        checks++;
        if ({o_in_ready, o_out_valid, o_out_data, o_done, o_state} !== 21'd0) begin
            errors++;
            $display("FAIL reset_init: got %h, required 0", {o_in_ready, o_out_valid, o_out_data, o_done, o_state});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        force_low = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data = 16'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL reset_pre: got valid=%b state=%0d, required valid=1 state=1", o_out_valid, o_state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_in_ready, o_out_valid, o_out_data, o_done, o_state} !== 21'd0) begin
            errors++;
            $display("FAIL reset_async: got %h, required 0", {o_in_ready, o_out_valid, o_out_data, o_done, o_state});
        end
        @(negedge clk);
        rst_n = 1'b1;
        force_low = 0;
        in_valid = 1'b1;
        in_data = 16'd77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_after: got valid=%b ready=%b state=%0d, required 0 0 0", o_out_valid, o_in_ready, o_state);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d dones, required 0", done_cnt - d0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        int o0, d0;
        for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
        o0 = out_cnt;
        d0 = done_cnt;
        check_lat = 1;
        drive_frame();
        check_lat = 0;
        checks++;
        if (out_cnt - o0 != 4 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ramp_count: got %0d outputs %0d dones, required 4 1", out_cnt - o0, done_cnt - d0);
        end
    endtask

    task automatic test_relu();
        for (int i = 0; i < 16; i++) pix[i] = -16'sd5;
        drive_frame();
        for (int i = 0; i < 16; i++) pix[i] = (i % 2) ? 16'sd2 : -16'sd3;
        drive_frame();
    endtask

    task automatic test_backpressure();
        int n, base;
        for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
        base = acc_cnt;
        stall_arm = 1;
        fork
            drive_frame();
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!o_out_valid && n < 50);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (o_out_valid !== 1'b1 || o_out_data !== 16'd6 || o_in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold: got valid=%b data=%0d in_ready=%b, required 1 6 0",
                                 o_out_valid, o_out_data, o_in_ready);
                    end
                end
                checks++;
                if (acc_cnt - base != 6) begin
                    errors++;
                    $display("FAIL bp_consumed: got %0d inputs, required 6", acc_cnt - base);
                end
            end
        join
    endtask

    task automatic test_ignored();
        int a0, o0;
        a0 = acc_cnt;
        in_valid = 1'b1;
        in_data = 16'd99;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (o_in_ready !== 1'b0 || o_state !== 2'd0) begin
                errors++;
                $display("FAIL idle_ignore: got ready=%b state=%0d, required 0 0", o_in_ready, o_state);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (acc_cnt != a0) begin
            errors++;
            $display("FAIL idle_accept: got %0d accepted, required 0", acc_cnt - a0);
        end
        for (int i = 0; i < 16; i++) pix[i] = 16'(3 * i - 20);
        o0 = out_cnt;
        start_at = 5;
        drive_frame();
        start_at = -1;
        checks++;
        if (out_cnt - o0 != 4) begin
            errors++;
            $display("FAIL start_in_run: got %0d outputs, required 4", out_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int o0, d0;
        o0 = out_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) pix[i] = 16'($urandom_range(0, 65535));
        drive_frame();
        for (int i = 0; i < 16; i++) pix[i] = 16'($urandom_range(0, 65535));
        drive_frame();
        checks++;
        if (out_cnt - o0 != 8 || done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs %0d dones, required 8 2", out_cnt - o0, done_cnt - d0);
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 16; i++) pix[i] = -16'sd32768;
        pix[1] = 16'sd32767;
        pix[8] = 16'sd32767;
        pix[13] = -16'sd1;
        pix[10] = -16'sd1;
        pix[14] = 16'sd0;
        drive_frame();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_relu();
        test_backpressure();
        test_ignored();
        test_back_to_back();
        test_extremes();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
